// File: rtl/sli_pkg.sv
// Shared types and constants for the SLI capture sequencer.
package sli_pkg;

  localparam int N_FRAMES_DEF = 32;
  localparam int FRAME_IDX_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_ADV       = 3'd2,
    S_WAIT_TRIG = 3'd3,
    S_EXPOSE    = 3'd4,
    S_WAIT_CAM  = 3'd5,
    S_FIN       = 3'd6
  } sli_state_e;

  // Pattern generation stays enabled from arming until the last frame is stored.
  function automatic logic state_drives_pipe(sli_state_e s);
    return (s == S_ARM) || (s == S_ADV) || (s == S_WAIT_TRIG) ||
           (s == S_EXPOSE) || (s == S_WAIT_CAM);
  endfunction

endpackage

// File: rtl/sli_sequencer_if.sv
// Control/status bundle between the SLI sequencer and its pattern pipe / camera.
// Handshake: start/abort/cam_done are single-cycle pulses sampled on posedge clk;
// rdy is a level held from entering ADV until one vsync edge has been seen.
interface sli_sequencer_if;
  logic start;
  logic abort;
  logic vsync;
  logic trig;
  logic f_frm;
  logic cam_done;
  logic mode;
  logic rdy;
  logic busy;
  logic done;
  logic err;
  logic [sli_pkg::FRAME_IDX_W-1:0] frame_idx;
  sli_pkg::sli_state_e             dbg_state;

  modport master (
    input  start, abort, vsync, trig, f_frm, cam_done,
    output mode, rdy, busy, done, err, frame_idx, dbg_state
  );

  modport slave (
    output start, abort, vsync, trig, f_frm, cam_done,
    input  mode, rdy, busy, done, err, frame_idx, dbg_state
  );
endinterface

// File: rtl/sli_edge_det.sv
// Single-register edge detector: edge = current sample versus the previous cycle's sample.
module sli_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/sli_sequencer.sv
// SLI capture sequencer: arms on vsync, steps the pattern pipe once per frame, counts camera frames.
// Optional watchdog on trigger/camera waits is enabled with SLI_SEQ_TIMEOUT_EN.
module sli_sequencer import sli_pkg::*; #(
  parameter int          N_FRAMES    = N_FRAMES_DEF,
  parameter logic [23:0] TIMEOUT_CYC = 24'h400000,
  parameter int          ARM_VS      = 2
) (
  input logic            clk,
  input logic            rst_n,
  sli_sequencer_if.master bus
);

  localparam logic [7:0]             ARM_LAST = 8'(ARM_VS - 1);
  localparam logic [FRAME_IDX_W-1:0] N_LAST   = FRAME_IDX_W'(N_FRAMES);

  // Assertion is immediate; release waits two clocks so no flop leaves reset mid-cycle.
  logic [1:0] rst_sync_q;
  logic       rst_sn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sn = rst_sync_q[1];

  logic vs_rise, vs_fall_unused, trig_rise, trig_fall;

  sli_edge_det u_vsync_edge (
    .clk    (clk),
    .rst_n  (rst_sn),
    .sig_i  (bus.vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall_unused)
  );

  sli_edge_det u_trig_edge (
    .clk    (clk),
    .rst_n  (rst_sn),
    .sig_i  (bus.trig),
    .rise_o (trig_rise),
    .fall_o (trig_fall)
  );

  sli_state_e             state_q, state_d;
  logic [FRAME_IDX_W-1:0] frame_idx_q, frame_idx_d, frame_next;
  logic [7:0]             arm_cnt_q, arm_cnt_d;
  logic                   err_q, err_d;
  logic                   mode_q, rdy_q, busy_q, done_q;
  logic                   frame_stored;

`ifdef SLI_SEQ_TIMEOUT_EN
  logic [23:0] wdog_q, wdog_d;
  logic        wd_watch, wd_expire;

  assign wd_watch  = (state_q == S_WAIT_TRIG) || (state_q == S_EXPOSE) ||
                     (state_q == S_WAIT_CAM);
  assign wd_expire = wd_watch && (wdog_q == TIMEOUT_CYC - 24'd1);

  // Any state change restarts the count, so each watched state gets a full budget.
  always_comb begin
    wdog_d = '0;
    if (wd_watch && (state_d == state_q)) wdog_d = wdog_q + 24'd1;
  end

  always_ff @(posedge clk or negedge rst_sn) begin
    if (!rst_sn) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  // Watchdog compiled out; the limit is still referenced so the parameter list is build-independent.
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = ^TIMEOUT_CYC;
`endif

  // A stored frame counts in WAIT_CAM, or in EXPOSE only on the exact trig-fall cycle.
  assign frame_stored = bus.cam_done &&
                        ((state_q == S_WAIT_CAM) || ((state_q == S_EXPOSE) && trig_fall));

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    arm_cnt_d   = arm_cnt_q;
    err_d       = err_q;
    frame_next  = frame_idx_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d     = S_ARM;
          frame_idx_d = '0;
          arm_cnt_d   = '0;
          err_d       = 1'b0;
        end
      end
      S_ARM: begin
        if (vs_rise) begin
          if (arm_cnt_q == ARM_LAST) begin
            if (bus.f_frm) begin
              state_d = S_ADV;
            end else begin
              err_d   = 1'b1;
              state_d = S_FIN;
            end
          end else begin
            arm_cnt_d = arm_cnt_q + 8'd1;
          end
        end
      end
      S_ADV:       if (vs_rise)   state_d = S_WAIT_TRIG;
      S_WAIT_TRIG: if (trig_rise) state_d = S_EXPOSE;
      S_EXPOSE:    if (trig_fall) state_d = S_WAIT_CAM;
      S_WAIT_CAM:  ;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (frame_stored) begin
      if (frame_idx_q < N_LAST) frame_idx_d = frame_next;
      state_d = (frame_next == N_LAST) ? S_FIN : S_ADV;
    end

`ifdef SLI_SEQ_TIMEOUT_EN
    if (wd_expire && (state_d == state_q)) begin
      err_d   = 1'b1;
      state_d = S_FIN;
    end
`endif

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      frame_idx_d = frame_idx_q;
      err_d       = err_q;
    end
  end

  // Outputs are registered from the next state so they line up with the new state.
  always_ff @(posedge clk or negedge rst_sn) begin
    if (!rst_sn) begin
      state_q     <= S_IDLE;
      frame_idx_q <= '0;
      arm_cnt_q   <= '0;
      err_q       <= 1'b0;
      mode_q      <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      arm_cnt_q   <= arm_cnt_d;
      err_q       <= err_d;
      mode_q      <= state_drives_pipe(state_d);
      rdy_q       <= (state_d == S_ADV);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
    end
  end

  assign bus.mode      = mode_q;
  assign bus.rdy       = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.frame_idx = frame_idx_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sli_sequencer.sv
// Randomised bench for sli_sequencer: camera/pipe responder, expected-result queue, done monitor.
module tb_sli_sequencer;
  import sli_pkg::*;

  localparam int N  = 32;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sli_sequencer_if bus ();

  sli_sequencer #(
    .N_FRAMES    (N),
    .TIMEOUT_CYC (24'(TO)),
    .ARM_VS      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pipe_adv = 0;
  int rdy_vs   = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_got, mon_exp;
  logic vs_prev = 1'b0;
  logic rdy_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input logic val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.rdy == val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_rdy: rdy stayed away from %0d for 600 cycles", val);
    end
  endtask

  task automatic wait_busy_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_busy_low: busy still 1 after 2000 cycles, expected 0");
    end
  endtask

  task automatic pulse_start();
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    check("start_busy", bus.busy, 1);
    check("start_mode", bus.mode, 1);
    check("start_err_clr", bus.err, 0);
    check("start_idx_clr", bus.frame_idx, 0);
  endtask

  // Drives one capture. abort_frame>=0 aborts in EXPOSE of that frame;
  // stall_frame>=0 withholds cam_done for that frame.
  task automatic run_capture(input int abort_frame, input int stall_frame);
    bit ok;
    int hold;
    bit coinc;
    int wd_n;
    bus.f_frm = 1'b1;
    pipe_adv  = 0;
    if (abort_frame < 0 && stall_frame < 0) exp_q.push_back({1'b0, 6'(N)});
`ifdef SLI_SEQ_TIMEOUT_EN
    if (stall_frame >= 0) exp_q.push_back({1'b1, 6'(stall_frame)});
`endif
    pulse_start();
    for (int f = 0; f < N; f++) begin
      wait_rdy(1'b1, ok);
      if (!ok) return;
      wait_rdy(1'b0, ok);
      if (!ok) return;
      cyc();
      repeat ($urandom_range(0, 3)) cyc();
      hold = $urandom_range(3, 6);
      bus.trig = 1'b1;
      for (int h = 0; h < hold; h++) begin
        bus.cam_done = (h == 1) && ($urandom_range(0, 1) == 1);
        bus.start    = (h == 2) && ($urandom_range(0, 1) == 1);
        bus.abort    = (h == 2) && (f == abort_frame);
        cyc();
        if (f == abort_frame && h == 2) break;
      end
      bus.cam_done = 1'b0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      if (f == abort_frame) begin
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_mode", bus.mode, 0);
        check("abort_rdy", bus.rdy, 0);
        check("abort_done", bus.done, 0);
        check("abort_idx", bus.frame_idx, abort_frame);
        cyc();
        bus.trig = 1'b0;
        repeat (40) cyc();
        check("abort_idx_hold", bus.frame_idx, abort_frame);
        return;
      end
      bus.trig = 1'b0;
      coinc = ($urandom_range(0, 2) == 0) && (f != stall_frame);
      bus.cam_done = coinc;
      cyc();
      bus.cam_done = 1'b0;
      if (f == stall_frame) begin
`ifdef SLI_SEQ_TIMEOUT_EN
        wd_n = 0;
        for (int k = 1; k <= TO + 100; k++) begin
          cyc();
          if (bus.err) begin
            wd_n = k;
            break;
          end
        end
        check("timeout_cycle", wd_n, TO);
        wait_busy_low(ok);
        check("timeout_err", bus.err, 1);
        check("timeout_idx", bus.frame_idx, stall_frame);
`else
        repeat (TO + 200) cyc();
        @(negedge clk);
        check("stall_busy", bus.busy, 1);
        check("stall_state", bus.dbg_state, S_WAIT_CAM);
        check("stall_err", bus.err, 0);
        cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        @(negedge clk);
        check("stall_abort_busy", bus.busy, 0);
        check("stall_abort_idx", bus.frame_idx, stall_frame);
`endif
        return;
      end
      if (!coinc) begin
        repeat ($urandom_range(0, 3)) cyc();
        bus.cam_done = 1'b1;
        cyc();
        bus.cam_done = 1'b0;
      end
    end
    wait_busy_low(ok);
    check("cap_idx", bus.frame_idx, N);
    check("cap_mode", bus.mode, 0);
    check("cap_rdy", bus.rdy, 0);
    check("cap_pipe_adv", pipe_adv, N);
    check("cap_err", bus.err, 0);
  endtask

  // Free-running vsync: random blanking, two-cycle pulse.
  initial begin
    bus.vsync = 1'b0;
    forever begin
      repeat ($urandom_range(10, 25)) @(posedge clk);
      #1 bus.vsync = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.vsync = 1'b0;
    end
  end

  // Monitor: pipe advances on rdy rise, one vsync rise per rdy window, done results from queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rdy && !rdy_prev) pipe_adv++;
      if (bus.rdy && bus.vsync && !vs_prev) rdy_vs++;
      if (!bus.rdy && rdy_prev) begin
        check("rdy_one_vsync", rdy_vs, 1);
        rdy_vs = 0;
      end
      if (bus.done) begin
        check("done_mode_low", bus.mode, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done err=%0d idx=%0d, expected no done",
                   bus.err, bus.frame_idx);
        end else begin
          mon_got = {bus.err, bus.frame_idx};
          mon_exp = exp_q.pop_front();
          check("done_result", mon_got, mon_exp);
        end
      end
    end
    vs_prev  = bus.vsync;
    rdy_prev = bus.rdy;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.trig     = 1'b0;
    bus.f_frm    = 1'b0;
    bus.cam_done = 1'b0;
    repeat (3) cyc();
    check("rst_mode", bus.mode, 0);
    check("rst_rdy", bus.rdy, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_idx", bus.frame_idx, 0);
    rst_n = 1'b1;
    repeat (4) cyc();

    run_capture(-1, -1);
    run_capture(-1, -1);

    // Arming with the pipe not at frequency 0 / phase 0.
    bus.f_frm = 1'b0;
    exp_q.push_back({1'b1, 6'd0});
    pulse_start();
    wait_busy_low(ok);
    check("arm_err_sticky", bus.err, 1);
    check("arm_err_idx", bus.frame_idx, 0);
    check("arm_err_mode", bus.mode, 0);
    repeat (10) cyc();
    check("arm_err_hold", bus.err, 1);

    run_capture(5, -1);
    run_capture(-1, 0);

    // Reset while waiting for the trigger.
    bus.f_frm = 1'b1;
    pulse_start();
    wait_rdy(1'b1, ok);
    wait_rdy(1'b0, ok);
    check("pre_rst_state", bus.dbg_state, S_WAIT_TRIG);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {bus.mode, bus.rdy, bus.busy, bus.done, bus.err, bus.frame_idx}, 0);
    check("midrst_state", bus.dbg_state, S_IDLE);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    run_capture(-1, -1);

    repeat (20) cyc();
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sli_sequencer.md
SLI_SEQUENCER -- requirements
Module: sli_sequencer

Interface
REQ-001 SHALL have parameter N_FRAMES, default 32, meaning SLI pattern advances per capture (4 spatial frequencies x 8 phases).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 24'h400000, meaning the camera/trigger watchdog limit in clk cycles.
REQ-003 SHALL have parameter ARM_VS, default 2, meaning the vsync rising edges to wait after mode=1 before the first advance.
REQ-004 SHALL have port clk, input, 1, pixel clock; the only clock.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a capture.
REQ-007 SHALL have port abort, input, 1, single-cycle request to cancel a capture.
REQ-008 SHALL have port vsync, input, 1, video vsync, synchronous to clk.
REQ-009 SHALL have port trig, input, 1, camera exposure strobe from the pattern pipe.
REQ-010 SHALL have port f_frm, input, 1, pattern pipe at frequency 0, phase 0.
REQ-011 SHALL have port cam_done, input, 1, single-cycle camera frame-stored pulse.
REQ-012 SHALL have port mode, output, 1, pattern-generation enable to the pattern pipe.
REQ-013 SHALL have port rdy, output, 1, pattern-advance request to the pattern pipe.
REQ-014 SHALL have port busy, output, 1, capture in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when a capture completes.
REQ-016 SHALL have port err, output, 1, sticky error flag, cleared by the next accepted start.
REQ-017 SHALL have port frame_idx, output, 6, count of completed advances.

Function
REQ-018 vsync edge SHALL be vsync high with vsync_q low (vsync_q = vsync registered once); trig rise/fall SHALL be detected the same way.
REQ-019 FSM states SHALL be IDLE, ARM, ADV, WAIT_TRIG, EXPOSE, WAIT_CAM, FIN.
REQ-020 IDLE: mode=0, rdy=0, busy=0; start SHALL go to ARM, clear frame_idx and err, and set mode=1 in the next cycle.
REQ-021 ARM: SHALL count ARM_VS vsync edges, then go to ADV if f_frm=1; if f_frm=0, SHALL set err and go to FIN.
REQ-022 ADV: rdy=1 until one vsync edge is seen, then rdy=0 in the following cycle and go to WAIT_TRIG; this gives the pipe one low-to-high rdy sample per advance.
REQ-023 WAIT_TRIG: trig rise SHALL go to EXPOSE.
REQ-024 EXPOSE: trig fall SHALL go to WAIT_CAM.
REQ-025 WAIT_CAM: cam_done SHALL increment frame_idx (6-bit, no wrap past N_FRAMES); if the new value equals N_FRAMES go to FIN, else go to ADV.
REQ-026 cam_done SHALL be ignored in every state except WAIT_CAM; a cam_done arriving in EXPOSE SHALL be counted only if it coincides with the trig-fall cycle.
REQ-027 FIN: mode=0, rdy=0, done=1 for exactly one cycle, then go to IDLE; done SHALL NOT pulse on the abort path.
REQ-028 abort in any non-IDLE state SHALL go to IDLE next cycle with mode=0 and rdy=0; frame_idx SHALL hold; abort SHALL win over a simultaneous start, cam_done or trig edge.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 busy SHALL be 1 in all states except IDLE.
REQ-031 Outputs SHALL be registered; rdy and mode SHALL change in the cycle after the state transition.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, mode=0, rdy=0, busy=0, done=0, err=0, frame_idx=0, and clear edge registers and the watchdog.
REQ-033 Reset asserted mid-capture SHALL abandon the capture with no done pulse; deassertion SHALL be synchronised to clk.

Configuration
REQ-034 With SLI_SEQ_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_TRIG, EXPOSE and WAIT_CAM, resetting on each state entry; reaching TIMEOUT_CYC SHALL set err and go to FIN.
REQ-035 Without SLI_SEQ_TIMEOUT_EN, there SHALL be no watchdog logic, these states SHALL wait indefinitely, and err SHALL be set only by REQ-021.

Structure
REQ-036 The state enum, the default N_FRAMES, and the frame_idx width SHALL live in package sli_pkg.
REQ-037 Edge detection SHALL be one sub-module, sli_edge_det, instantiated for vsync and trig.

Verification
REQ-038 Bench SHALL cover a full capture: start, f_frm=1, 32 trig/cam_done cycles -> 32 rdy pulses, frame_idx=32, one done, mode=0 after FIN.
REQ-039 Bench SHALL cover rdy timing: rdy=1 across exactly one vsync rise and 0 at the next -> pipe model advances once per frame.
REQ-040 Bench SHALL cover abort in EXPOSE at frame 5 -> IDLE next cycle, frame_idx=5, no done, mode=0.
REQ-041 Bench SHALL cover ARM with f_frm=0 after 2 vsync edges -> err=1, done pulse, frame_idx=0.
REQ-042 Bench SHALL cover the timeout (SLI_SEQ_TIMEOUT_EN, TIMEOUT_CYC=1000) with cam_done withheld -> err=1 at cycle 1000 of WAIT_CAM; without the macro, FSM stays in WAIT_CAM.
REQ-043 Bench SHALL cover rst_n low during WAIT_TRIG -> all outputs 0 immediately; a later start runs a clean capture.
